// File: rtl/rom_loader_pkg.sv
// Shared definitions for the rom_loader program loader.
//   - state_e      : loader FSM states
//   - SYNC_BYTE    : frame start marker
//   - ERR_*        : ErrCode encodings
//   - DEF_ADDR_W / DEF_DATA_W : default instruction memory geometry
//   - MAX_COUNT    : largest legal word count in a frame
//   - count_ok()   : legality test for the 16-bit COUNT field
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    WORD   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_FORMAT   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 29;

  localparam logic [15:0] MAX_COUNT = 16'd2048;

  function automatic logic count_ok(input logic [15:0] cnt);
    return (cnt != 16'd0) && (cnt <= MAX_COUNT);
  endfunction

endpackage

// File: rtl/rom_loader_asm.sv
// Big-endian word assembler for rom_loader.
// Shifts word bytes in MSB first and keeps the running XOR checksum.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : clear shift register and checksum (start of frame)
//   en_i         : accept byte_i as a word byte
//   byte_i       : incoming byte
//   idx_i        : position of byte_i within its word (0 = MSB)
//   word_o       : word formed by the three previously shifted bytes and byte_i
//   fmt_err_o    : byte_i is a first word byte with nonzero bits [7:5]
//   chk_o        : XOR of all word bytes accepted since clr_i
module rom_loader_asm
  import rom_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [7:0]        byte_i,
  input  logic [1:0]        idx_i,
  output logic [DATA_W-1:0] word_o,
  output logic              fmt_err_o,
  output logic [7:0]        chk_o
);

  // Only DATA_W-8 bits of history are needed: the top bits of the first
  // byte fall off the left end, which is exactly the truncation to DATA_W.
  logic [DATA_W-9:0] shift_q, shift_d;
  logic [7:0]        chk_q, chk_d;

  assign word_o    = {shift_q, byte_i};
  assign fmt_err_o = (idx_i == 2'd0) && (byte_i[7:5] != 3'b000);
  assign chk_o     = chk_q;

  always_comb begin
    shift_d = shift_q;
    chk_d   = chk_q;
    if (clr_i) begin
      shift_d = '0;
      chk_d   = 8'h00;
    end else if (en_i) begin
      shift_d = {shift_q[DATA_W-17:0], byte_i};
      chk_d   = chk_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      chk_q   <= 8'h00;
    end else begin
      shift_q <= shift_d;
      chk_q   <= chk_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Byte-stream program loader: parses A5 | COUNT_HI | COUNT_LO | words | XOR
// frames and writes each 4-byte big-endian word into instruction memory.
// Optional inter-byte timeout is enabled with the macro ROM_LOADER_TIMEOUT_EN.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   RxData, RxValid   : received byte and its one-cycle strobe (no backpressure)
//   WeRAM             : one-cycle write pulse
//   AddrRAM, DataRAM  : registered write address / data
//   Busy, HoldCPU     : frame in progress (HoldCPU mirrors Busy)
//   Done              : last frame loaded with correct checksum
//   ErrCode           : 00 none, 01 checksum, 10 format/count, 11 timeout
//   dbg_state_o       : current FSM state (state_e encoding)
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              WeRAM,
  output logic [ADDR_W-1:0] AddrRAM,
  output logic [DATA_W-1:0] DataRAM,
  output logic              Busy,
  output logic              HoldCPU,
  output logic              Done,
  output logic [1:0]        ErrCode,
  output logic [2:0]        dbg_state_o
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;        // address presented with WeRAM
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;  // next address to be written
  logic [ADDR_W:0]   rem_q, rem_d;          // words still to receive
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;

  logic              asm_clr, asm_en, asm_fmt_err;
  logic [DATA_W-1:0] asm_word;
  logic [7:0]        asm_chk;
  logic [15:0]       count_w;
  logic              timeout_hit;

  assign count_w = {cnt_hi_q, RxData};

  rom_loader_asm #(.DATA_W(DATA_W)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (asm_clr),
    .en_i      (asm_en),
    .byte_i    (RxData),
    .idx_i     (idx_q),
    .word_o    (asm_word),
    .fmt_err_o (asm_fmt_err),
    .chk_o     (asm_chk)
  );

`ifdef ROM_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts idle cycles while a frame is open; any byte restarts it.
  assign tmo_d       = (!busy_q || RxValid) ? '0 : tmo_q + 1'b1;
  assign timeout_hit = busy_q && !RxValid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_addr_d = wr_addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    cnt_hi_d  = cnt_hi_q;
    asm_clr   = 1'b0;
    asm_en    = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (RxValid && RxData == SYNC_BYTE) begin
          state_d   = CNT_HI;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = ERR_NONE;
          wr_addr_d = '0;
          asm_clr   = 1'b1;
        end
      end
      CNT_HI: begin
        if (RxValid) begin
          cnt_hi_d = RxData;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (RxValid) begin
          if (count_ok(count_w)) begin
            rem_d   = count_w[ADDR_W:0];
            idx_d   = 2'd0;
            state_d = WORD;
          end else begin
            state_d = ERR;
            busy_d  = 1'b0;
            err_d   = ERR_FORMAT;
          end
        end
      end
      WORD: begin
        if (RxValid) begin
          if (asm_fmt_err) begin
            state_d = ERR;
            busy_d  = 1'b0;
            err_d   = ERR_FORMAT;
          end else begin
            asm_en = 1'b1;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              we_d      = 1'b1;
              addr_d    = wr_addr_q;
              data_d    = asm_word;
              wr_addr_d = wr_addr_q + 1'b1;
              rem_d     = rem_q - 1'b1;
              if (rem_q == (ADDR_W+1)'(1)) state_d = CHK;
            end
          end
        end
      end
      CHK: begin
        if (RxValid) begin
          busy_d = 1'b0;
          if (RxData == asm_chk) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = ERR_CHECKSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Only reachable with no byte present, so no write can coincide.
    if (timeout_hit) begin
      state_d = ERR;
      busy_d  = 1'b0;
      err_d   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_addr_q <= '0;
      rem_q     <= '0;
      idx_q     <= 2'd0;
      cnt_hi_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_addr_q <= wr_addr_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      cnt_hi_q  <= cnt_hi_d;
    end
  end

  assign WeRAM       = we_q;
  assign AddrRAM     = addr_q;
  assign DataRAM     = data_q;
  assign Busy        = busy_q;
  assign HoldCPU     = busy_q;
  assign Done        = done_q;
  assign ErrCode     = err_q;
  assign dbg_state_o = state_q;

endmodule
